// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage with stall tolerance and self-draining.
// Optional SDF_ROUND_EN: round-half-up with saturation when SCALE=1.
module sdf_r2_stage #(
   parameter int WIDTH = 8,
   parameter int DELAY = 16,
   parameter int SCALE = 0,
   localparam int OUT_WIDTH = (SCALE != 0) ? WIDTH : WIDTH + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable_in,
   input  logic signed [WIDTH-1:0]     in_re,
   input  logic signed [WIDTH-1:0]     in_im,
   output logic                        enable_out,
   output logic signed [OUT_WIDTH-1:0] out_re,
   output logic signed [OUT_WIDTH-1:0] out_im
);

   localparam int CW = $clog2(DELAY) + 1;

   typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_nxt;
   logic                    drain_pend;
   logic                    drain_pend_nxt;
   logic                    slot;
   logic                    phase;
   logic                    drain_done;
   logic signed [WIDTH:0]   dl_re [DELAY];
   logic signed [WIDTH:0]   dl_im [DELAY];
   logic signed [WIDTH:0]   x_re;
   logic signed [WIDTH:0]   x_im;
   logic signed [WIDTH:0]   head_re;
   logic signed [WIDTH:0]   head_im;
   logic signed [WIDTH:0]   push_re;
   logic signed [WIDTH:0]   push_im;
   logic signed [WIDTH:0]   res_re;
   logic signed [WIDTH:0]   res_im;

   function automatic logic signed [OUT_WIDTH-1:0] scale_val(input logic signed [WIDTH:0] v);
      logic signed [WIDTH+1:0] r;
      logic signed [OUT_WIDTH-1:0] o;
      r = (WIDTH+2)'(v);
      if (SCALE == 0) begin
         o = OUT_WIDTH'(v);
      end else begin
`ifdef SDF_ROUND_EN
         r = ((WIDTH+2)'(v) + (WIDTH+2)'(1)) >>> 1;
         if (r == (WIDTH+2)'(2**(WIDTH-1))) begin
            o = OUT_WIDTH'(2**(WIDTH-1) - 1);
         end else begin
            o = OUT_WIDTH'(r);
         end
`else
         o = OUT_WIDTH'(r >>> 1);
`endif
      end
      return o;
   endfunction

   // slot decode, butterfly arithmetic and next counter/state
   always_comb begin
      phase   = (state == RUN);
      slot    = enable_in | (state == DRAIN);
      x_re    = enable_in ? (WIDTH+1)'(in_re) : {(WIDTH+1){1'b0}};
      x_im    = enable_in ? (WIDTH+1)'(in_im) : {(WIDTH+1){1'b0}};
      head_re = dl_re[DELAY-1];
      head_im = dl_im[DELAY-1];
      if (phase) begin
         res_re  = head_re + x_re;
         res_im  = head_im + x_im;
         push_re = head_re - x_re;
         push_im = head_im - x_im;
      end else begin
         res_re  = head_re;
         res_im  = head_im;
         push_re = x_re;
         push_im = x_im;
      end
      drain_done     = slot & ~phase & ~enable_in & (cnt == CW'(DELAY - 1));
      cnt_nxt        = cnt;
      drain_pend_nxt = drain_pend;
      if (slot) begin
         // the last drained difference returns the counter to frame start
         if (drain_done) begin
            cnt_nxt        = {CW{1'b0}};
            drain_pend_nxt = 1'b0;
         end else begin
            cnt_nxt = cnt + CW'(1);
            if (phase) begin
               drain_pend_nxt = 1'b1;
            end else begin
               drain_pend_nxt = drain_pend;
            end
         end
      end else begin
         cnt_nxt = cnt;
      end
      if (cnt_nxt[CW-1]) begin
         state_nxt = RUN;
      end else if (drain_pend_nxt) begin
         state_nxt = DRAIN;
      end else if (cnt_nxt == {CW{1'b0}}) begin
         state_nxt = IDLE;
      end else begin
         state_nxt = FILL;
      end
   end

   // control state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= {CW{1'b0}};
         drain_pend <= 1'b0;
         state      <= IDLE;
         enable_out <= 1'b0;
         out_re     <= {OUT_WIDTH{1'b0}};
         out_im     <= {OUT_WIDTH{1'b0}};
      end else begin
         cnt        <= cnt_nxt;
         drain_pend <= drain_pend_nxt;
         state      <= state_nxt;
         if (slot) begin
            enable_out <= phase | drain_pend;
            out_re     <= scale_val(res_re);
            out_im     <= scale_val(res_im);
         end else begin
            enable_out <= 1'b0;
         end
      end
   end

   // feedback delay line, advances one position per slot
   always_ff @(posedge clk) begin
      if (slot) begin
         dl_re[0] <= push_re;
         dl_im[0] <= push_im;
         for (int i = 1; i < DELAY; i++) begin
            dl_re[i] <= dl_re[i-1];
            dl_im[i] <= dl_im[i-1];
         end
      end
   end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Bench for sdf_r2_stage: cycle tables for the timing corner cases, random frames against a
// frame-level butterfly model (sums then differences per frame, in stream order).
module tb_sdf_r2_stage;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int OW = W + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en_in;
   logic signed [W-1:0]  in_re;
   logic signed [W-1:0]  in_im;
   logic                 en_out;
   logic signed [OW-1:0] out_re;
   logic signed [OW-1:0] out_im;
   logic                 s_en_in;
   logic signed [W-1:0]  s_in_re;
   logic signed [W-1:0]  s_in_im;
   logic                 s_en_out;
   logic signed [W-1:0]  s_out_re;
   logic signed [W-1:0]  s_out_im;

   always #5 clk = ~clk;

   sdf_r2_stage #(.WIDTH(W), .DELAY(D), .SCALE(0)) dut (
      .clk(clk), .rst(rst), .enable_in(en_in), .in_re(in_re), .in_im(in_im),
      .enable_out(en_out), .out_re(out_re), .out_im(out_im));

   sdf_r2_stage #(.WIDTH(W), .DELAY(1), .SCALE(1)) dut_s (
      .clk(clk), .rst(rst), .enable_in(s_en_in), .in_re(s_in_re), .in_im(s_in_im),
      .enable_out(s_en_out), .out_re(s_out_re), .out_im(s_out_im));

   typedef struct {
      string tag;
      bit    r;
      bit    en;
      int    re;
      int    im;
      bit    exp_en;
      int    exp_re;
      int    exp_im;
   } vec_t;

   vec_t tbl[$];
   int   q_re[$];
   int   q_im[$];
   int   qs_re[$];
   int   qs_im[$];
   bit   mon_m = 1'b0;
   bit   mon_s = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input integer act, input integer exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // expected SCALE=1 result from the exact sum/difference
   function automatic int scl(input int v);
      int r;
`ifdef SDF_ROUND_EN
      r = (v + 1) >>> 1;
      if (r == 128) r = 127;
`else
      r = v >>> 1;
`endif
      return r;
   endfunction

   task automatic step(input bit r, input bit e, input int re, input int im,
                       input bit se, input int sre, input int sim);
      rst     = r;
      en_in   = e;
      in_re   = re[W-1:0];
      in_im   = im[W-1:0];
      s_en_in = se;
      s_in_re = sre[W-1:0];
      s_in_im = sim[W-1:0];
      @(posedge clk);
      #1;
      if (mon_m && en_out) begin
         if (q_re.size() == 0) begin
            check("rand_extra_out", 1, 0);
         end else begin
            check("rand_re", out_re, q_re.pop_front());
            check("rand_im", out_im, q_im.pop_front());
         end
      end
      if (mon_s && s_en_out) begin
         if (qs_re.size() == 0) begin
            check("srand_extra_out", 1, 0);
         end else begin
            check("srand_re", s_out_re, qs_re.pop_front());
            check("srand_im", s_out_im, qs_im.pop_front());
         end
      end
   endtask

   function automatic void add(input string tag, input bit r, input bit en, input int re, input int im,
                               input bit ee, input int er, input int ei);
      vec_t v;
      v.tag = tag; v.r = r; v.en = en; v.re = re; v.im = im;
      v.exp_en = ee; v.exp_re = er; v.exp_im = ei;
      tbl.push_back(v);
   endfunction

   function automatic void add_single(input string tag);
      for (int s = 0; s < 14; s++) begin
         add(tag, 1'b0, s < 8, (s < 8) ? s : 0, 0, (s >= 4 && s < 12),
             (((s / 4) % 2) == 1) ? 2 * s - 4 : -4, 0);
      end
   endfunction

   initial begin
      int a, b, nst, gap;
      int fr_re[2*D];
      int fr_im[2*D];

      // single frame: in_re 0..7, outputs 4,6,8,10 then -4 x4
      add_single("single");
      // two back-to-back frames, second frame in_im = 1
      for (int s = 0; s < 22; s++) begin
         add("b2b", 1'b0, s < 16, (s < 16) ? s : 0, (s >= 8 && s < 16) ? 1 : 0,
             (s >= 4 && s < 20), (((s / 4) % 2) == 1) ? 2 * s - 4 : -4,
             (s >= 12 && s < 16) ? 2 : 0);
      end
      // three stalled cycles after x[5]
      for (int s = 0; s < 17; s++) begin
         add("stall", 1'b0, (s <= 5) || s == 9 || s == 10,
             (s <= 5) ? s : (s == 9) ? 6 : (s == 10) ? 7 : 0, 0,
             (s >= 4 && s <= 5) || (s >= 9 && s <= 14),
             (s == 4) ? 4 : (s == 5) ? 6 : (s == 9) ? 8 : (s == 10) ? 10 : -4, 0);
      end
      // aborted frame, reset pulse, then a fresh frame
      for (int s = 0; s < 6; s++) begin
         add("abort", 1'b0, 1'b1, 100 + s, -3, s >= 4, (s == 4) ? 204 : 206, -6);
      end
      add("abort_rst", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
      add_single("refill");

      // reset held 3 cycles, then 20 idle cycles
      for (int i = 0; i < 23; i++) begin
         step(i < 3, 1'b0, 0, 0, 1'b0, 0, 0);
         check("idle_en", en_out, 0);
         check("idle_re", out_re, 0);
         check("idle_im", out_im, 0);
         check("idle_s_en", s_en_out, 0);
         check("idle_s_re", s_out_re, 0);
      end

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].en, tbl[i].re, tbl[i].im, 1'b0, 0, 0);
         check({tbl[i].tag, "_en"}, en_out, tbl[i].exp_en);
         if (tbl[i].exp_en || tbl[i].r) begin
            check({tbl[i].tag, "_re"}, out_re, tbl[i].exp_re);
            check({tbl[i].tag, "_im"}, out_im, tbl[i].exp_im);
         end
      end

      // SCALE=1, DELAY=1: 127 then -128
      step(1'b0, 1'b0, 0, 0, 1'b1, 127, 5);
      check("scl_en0", s_en_out, 0);
      step(1'b0, 1'b0, 0, 0, 1'b1, -128, 3);
      check("scl_en1", s_en_out, 1);
      check("scl_sum_re", s_out_re, scl(-1));
      check("scl_sum_im", s_out_im, scl(8));
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
      check("scl_en2", s_en_out, 1);
      check("scl_diff_re", s_out_re, scl(255));
      check("scl_diff_im", s_out_im, scl(2));
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
      check("scl_en3", s_en_out, 0);

      // random frames on the DELAY=4 stage
      mon_m = 1'b1;
      for (int f = 0; f < 30; f++) begin
         for (int j = 0; j < 2 * D; j++) begin
            fr_re[j] = int'($urandom_range(0, 255)) - 128;
            fr_im[j] = int'($urandom_range(0, 255)) - 128;
         end
         for (int j = 0; j < D; j++) begin
            q_re.push_back(fr_re[j] + fr_re[j+D]);
            q_im.push_back(fr_im[j] + fr_im[j+D]);
         end
         for (int j = 0; j < D; j++) begin
            q_re.push_back(fr_re[j] - fr_re[j+D]);
            q_im.push_back(fr_im[j] - fr_im[j+D]);
         end
         for (int j = 0; j < 2 * D; j++) begin
            if (j >= D) begin
               nst = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
               for (int k = 0; k < nst; k++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
            end
            step(1'b0, 1'b1, fr_re[j], fr_im[j], 1'b0, 0, 0);
         end
         gap = ($urandom_range(0, 1) == 0) ? 0 : D + 2 + int'($urandom_range(0, 3));
         for (int k = 0; k < gap; k++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
      end
      for (int k = 0; k < D + 4; k++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
      check("rand_left", q_re.size(), 0);
      mon_m = 1'b0;

      // random pairs on the scaled DELAY=1 stage
      mon_s = 1'b1;
      for (int f = 0; f < 40; f++) begin
         a = int'($urandom_range(0, 255)) - 128;
         b = int'($urandom_range(0, 255)) - 128;
         qs_re.push_back(scl(a + b));
         qs_re.push_back(scl(a - b));
         qs_im.push_back(scl(b + a));
         qs_im.push_back(scl(b - a));
         step(1'b0, 1'b0, 0, 0, 1'b1, a, b);
         nst = int'($urandom_range(0, 2));
         for (int k = 0; k < nst; k++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
         step(1'b0, 1'b0, 0, 0, 1'b1, b, a);
         gap = int'($urandom_range(0, 3));
         for (int k = 0; k < gap; k++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
      end
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
      check("srand_left", qs_re.size(), 0);
      mon_s = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
